// File: rtl/zsram_access_sequencer.sv
// -----------------------------------------------------------------------------
// zsram_access_sequencer
// Turns word read/write requests into timed row strobes for the Zero Second RAM
// cell array: SETUP (data/address settle), STROBE (row edge high), HOLD (data
// held after the edge drops), RESPOND (one-cycle completion pulse).
//
// Ports
//   Clock, Reset        : rising-edge clock, synchronous active-high reset
//   requestValid/Ready  : request handshake; Ready is high only in IDLE
//   requestWrite        : 1 = write, 0 = read
//   requestAddress/Data : row select and write word
//   responseValid       : one-cycle pulse per completed request
//   responseData        : read word, captured at the end of the strobe
//   cellInputData       : shared write bit-lines to every row
//   cellWriteEdge       : per-row WriteEdge (one-hot or zero)
//   cellReadEdge        : per-row ReadEdge (one-hot or zero)
//   cellOutputData      : shared read bit-lines from every row
// -----------------------------------------------------------------------------
module zsram_access_sequencer #(
    parameter int unsigned ADDR_WIDTH    = 4,
    parameter int unsigned DATA_WIDTH    = 8,
    parameter int unsigned SETUP_CYCLES  = 1,
    parameter int unsigned STROBE_CYCLES = 2,
    parameter int unsigned HOLD_CYCLES   = 1
) (
    input  logic                       Clock,
    input  logic                       Reset,
    input  logic                       requestValid,
    output logic                       requestReady,
    input  logic                       requestWrite,
    input  logic [ADDR_WIDTH-1:0]      requestAddress,
    input  logic [DATA_WIDTH-1:0]      requestData,
    output logic                       responseValid,
    output logic [DATA_WIDTH-1:0]      responseData,
    output logic [DATA_WIDTH-1:0]      cellInputData,
    output logic [(2**ADDR_WIDTH)-1:0] cellWriteEdge,
    output logic [(2**ADDR_WIDTH)-1:0] cellReadEdge,
    input  logic [DATA_WIDTH-1:0]      cellOutputData
);

    localparam int unsigned ROWS      = 2 ** ADDR_WIDTH;
    localparam int unsigned CNT_WIDTH = 4;

    // The phase counter is 4 bits wide, so each phase length must fit 1..15.
    if (SETUP_CYCLES == 0 || SETUP_CYCLES > 15) begin : gBadSetup
        $error("SETUP_CYCLES must be in 1..15");
    end
    if (STROBE_CYCLES == 0 || STROBE_CYCLES > 15) begin : gBadStrobe
        $error("STROBE_CYCLES must be in 1..15");
    end
    if (HOLD_CYCLES == 0 || HOLD_CYCLES > 15) begin : gBadHold
        $error("HOLD_CYCLES must be in 1..15");
    end

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        SETUP   = 3'd1,
        STROBE  = 3'd2,
        HOLD    = 3'd3,
        RESPOND = 3'd4
    } seqState_t;

    seqState_t              state;
    logic [CNT_WIDTH-1:0]   phaseCount;
    logic                   latchedWrite;
    logic [ADDR_WIDTH-1:0]  latchedAddress;
    logic [ROWS-1:0]        rowOneHot;

    // Row decode of the latched address; bit 0 is row 0, MSB is the last row.
    assign rowOneHot = ROWS'(1) << latchedAddress;

    // Sequencer: each phase reloads the counter with (length - 1) on entry and
    // leaves when it reaches zero, giving exactly the configured cycle count.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            state          <= IDLE;
            phaseCount     <= '0;
            latchedWrite   <= 1'b0;
            latchedAddress <= '0;
            requestReady   <= 1'b1;
            responseValid  <= 1'b0;
            responseData   <= '0;
            cellInputData  <= '0;
            cellWriteEdge  <= '0;
            cellReadEdge   <= '0;
        end else begin
            responseValid <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (requestValid && requestReady) begin
                        state          <= SETUP;
                        requestReady   <= 1'b0;
                        latchedWrite   <= requestWrite;
                        latchedAddress <= requestAddress;
                        phaseCount     <= CNT_WIDTH'(SETUP_CYCLES - 1);
                        // Reads leave the write bit-lines at zero.
                        cellInputData  <= requestWrite ? requestData : '0;
                    end
                end
                SETUP: begin
                    if (phaseCount == '0) begin
                        state      <= STROBE;
                        phaseCount <= CNT_WIDTH'(STROBE_CYCLES - 1);
                        if (latchedWrite) begin
                            cellWriteEdge <= rowOneHot;
                        end else begin
                            cellReadEdge <= rowOneHot;
                        end
                    end else begin
                        phaseCount <= phaseCount - CNT_WIDTH'(1);
                    end
                end
                STROBE: begin
                    if (phaseCount == '0) begin
                        state         <= HOLD;
                        phaseCount    <= CNT_WIDTH'(HOLD_CYCLES - 1);
                        cellWriteEdge <= '0;
                        cellReadEdge  <= '0;
                        // Bit-lines are sampled while the read edge is still high.
                        if (!latchedWrite) begin
                            responseData <= cellOutputData;
                        end
                    end else begin
                        phaseCount <= phaseCount - CNT_WIDTH'(1);
                    end
                end
                HOLD: begin
                    if (phaseCount == '0) begin
                        state         <= RESPOND;
                        phaseCount    <= '0;
                        responseValid <= 1'b1;
                        cellInputData <= '0;
                    end else begin
                        phaseCount <= phaseCount - CNT_WIDTH'(1);
                    end
                end
                RESPOND: begin
                    state        <= IDLE;
                    requestReady <= 1'b1;
                end
                default: begin
                    state         <= IDLE;
                    phaseCount    <= '0;
                    requestReady  <= 1'b1;
                    cellInputData <= '0;
                    cellWriteEdge <= '0;
                    cellReadEdge  <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_zsram_access_sequencer.sv
// -----------------------------------------------------------------------------
// tb_zsram_access_sequencer
// Two sequencer instances (default timing and SETUP=3/STROBE=1/HOLD=2), each
// attached to a behavioural cell array. Expected per-cycle traces are derived
// from the phase lengths and a reference memory.
// -----------------------------------------------------------------------------
module tb_zsram_access_sequencer;

    localparam int unsigned AW   = 4;
    localparam int unsigned DW   = 8;
    localparam int unsigned ROWS = 16;
    localparam int unsigned NDUT = 2;

    typedef struct {
        bit            wr;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        bit            holdValid;
        logic [DW-1:0] expResp;
    } vec_t;

    logic clk;
    logic rst;

    logic            reqValid [NDUT];
    logic            reqReady [NDUT];
    logic            reqWrite [NDUT];
    logic [AW-1:0]   reqAddr  [NDUT];
    logic [DW-1:0]   reqData  [NDUT];
    logic            respValid[NDUT];
    logic [DW-1:0]   respData [NDUT];
    logic [DW-1:0]   cIn      [NDUT];
    logic [ROWS-1:0] cWe      [NDUT];
    logic [ROWS-1:0] cRe      [NDUT];
    logic [DW-1:0]   cOut     [NDUT];

    logic [DW-1:0]   arrayMem [NDUT][ROWS];
    logic [DW-1:0]   refMem   [NDUT][ROWS];
    logic [DW-1:0]   junk     [NDUT];
    logic [DW-1:0]   lastResp [NDUT];
    logic [DW-1:0]   prevIn   [NDUT];

    int  vectors;
    int  miscompares;
    bit  invariantsOn;

    function automatic int setupOf(input int u);
        return (u == 0) ? 1 : 3;
    endfunction
    function automatic int strobeOf(input int u);
        return (u == 0) ? 2 : 1;
    endfunction
    function automatic int holdOf(input int u);
        return (u == 0) ? 1 : 2;
    endfunction

    function automatic int oneHotIndex(input logic [ROWS-1:0] v);
        int idx = 0;
        for (int i = 0; i < int'(ROWS); i++) begin
            if (v[i]) idx = i;
        end
        return idx;
    endfunction

    zsram_access_sequencer #(
        .ADDR_WIDTH(4), .DATA_WIDTH(8),
        .SETUP_CYCLES(1), .STROBE_CYCLES(2), .HOLD_CYCLES(1)
    ) dut0 (
        .Clock(clk), .Reset(rst),
        .requestValid(reqValid[0]), .requestReady(reqReady[0]),
        .requestWrite(reqWrite[0]), .requestAddress(reqAddr[0]),
        .requestData(reqData[0]), .responseValid(respValid[0]),
        .responseData(respData[0]), .cellInputData(cIn[0]),
        .cellWriteEdge(cWe[0]), .cellReadEdge(cRe[0]),
        .cellOutputData(cOut[0])
    );

    zsram_access_sequencer #(
        .ADDR_WIDTH(4), .DATA_WIDTH(8),
        .SETUP_CYCLES(3), .STROBE_CYCLES(1), .HOLD_CYCLES(2)
    ) dut1 (
        .Clock(clk), .Reset(rst),
        .requestValid(reqValid[1]), .requestReady(reqReady[1]),
        .requestWrite(reqWrite[1]), .requestAddress(reqAddr[1]),
        .requestData(reqData[1]), .responseValid(respValid[1]),
        .responseData(respData[1]), .cellInputData(cIn[1]),
        .cellWriteEdge(cWe[1]), .cellReadEdge(cRe[1]),
        .cellOutputData(cOut[1])
    );

    // Behavioural cell array: the selected row drives the read bit-lines while
    // its ReadEdge is high; otherwise the lines carry garbage.
    for (genvar g = 0; g < int'(NDUT); g++) begin : gArray
        assign cOut[g] = (|cRe[g]) ? arrayMem[g][oneHotIndex(cRe[g])] : junk[g];
    end

    always @(posedge clk) begin
        for (int u = 0; u < int'(NDUT); u++) begin
            if (|cWe[u]) arrayMem[u][oneHotIndex(cWe[u])] = cIn[u];
            junk[u] = DW'($urandom);
        end
    end

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Edge-vector invariants and data stability during strobes.
    always @(negedge clk) begin
        for (int u = 0; u < int'(NDUT); u++) begin
            if (invariantsOn && !rst) begin
                check($sformatf("inv%0d both edges", u),
                      32'((|cWe[u]) && (|cRe[u])), 32'd0);
                check($sformatf("inv%0d onehot", u),
                      32'(($countones(cWe[u]) + $countones(cRe[u])) > 1), 32'd0);
                if ((|cWe[u]) || (|cRe[u]))
                    check($sformatf("inv%0d data stable", u), 32'(cIn[u]), 32'(prevIn[u]));
            end
            prevIn[u] = cIn[u];
        end
    end

    task automatic idleCheck(input int u, input string tag);
        check({tag, " idle cIn"}, 32'(cIn[u]), 32'd0);
        check({tag, " idle we"}, 32'(cWe[u]), 32'd0);
        check({tag, " idle re"}, 32'(cRe[u]), 32'd0);
        check({tag, " idle respValid"}, 32'(respValid[u]), 32'd0);
        check({tag, " idle ready"}, 32'(reqReady[u]), 32'd1);
    endtask

    // One request on instance u. Returns at the falling edge of the RESPOND
    // cycle; holdValid leaves requestValid asserted through the busy period.
    task automatic runTxn(input int u, input bit wr, input logic [AW-1:0] a,
                          input logic [DW-1:0] d, input bit holdValid,
                          input logic [DW-1:0] expResp, input string tag);
        int s = setupOf(u);
        int t = strobeOf(u);
        int h = holdOf(u);
        int b = s + t + h + 1;
        logic [ROWS-1:0] row;
        logic [ROWS-1:0] expEdge;
        logic [DW-1:0]   expIn;
        row = ROWS'(1) << a;
        @(posedge clk);
        #1;
        reqValid[u] = 1'b1;
        reqWrite[u] = wr;
        reqAddr[u]  = a;
        reqData[u]  = d;
        @(negedge clk);
        check({tag, " ready before"}, 32'(reqReady[u]), 32'd1);
        @(posedge clk);
        #1;
        if (!holdValid) reqValid[u] = 1'b0;
        for (int k = 1; k <= b; k++) begin
            @(negedge clk);
            expIn   = (wr && k <= s + t + h) ? d : '0;
            expEdge = (k > s && k <= s + t) ? row : '0;
            check($sformatf("%s c%0d cIn", tag, k), 32'(cIn[u]), 32'(expIn));
            check($sformatf("%s c%0d we", tag, k), 32'(cWe[u]), wr ? 32'(expEdge) : 32'd0);
            check($sformatf("%s c%0d re", tag, k), 32'(cRe[u]), wr ? 32'd0 : 32'(expEdge));
            check($sformatf("%s c%0d respValid", tag, k), 32'(respValid[u]), 32'(k == b));
            check($sformatf("%s c%0d ready", tag, k), 32'(reqReady[u]), 32'd0);
            if (k == b) check({tag, " respData"}, 32'(respData[u]), 32'(expResp));
        end
        if (wr) refMem[u][a] = d;
        else    lastResp[u]  = expResp;
    endtask

    vec_t vecs[9];

    initial begin
        vec_t v;
        vectors      = 0;
        miscompares  = 0;
        invariantsOn = 1'b0;
        rst          = 1'b1;
        for (int u = 0; u < int'(NDUT); u++) begin
            reqValid[u] = 1'b0;
            reqWrite[u] = 1'b0;
            reqAddr[u]  = '0;
            reqData[u]  = '0;
            lastResp[u] = '0;
            junk[u]     = '0;
            prevIn[u]   = '0;
            for (int r = 0; r < int'(ROWS); r++) begin
                arrayMem[u][r] = DW'($urandom);
                refMem[u][r]   = arrayMem[u][r];
            end
        end
        arrayMem[0][15] = 8'h3C;
        refMem[0][15]   = 8'h3C;

        // Directed table for the default-timing instance.
        vecs[0] = '{wr: 1'b1, addr: 4'd3,  data: 8'hA5, holdValid: 1'b0, expResp: 8'h00};
        vecs[1] = '{wr: 1'b0, addr: 4'd15, data: 8'h00, holdValid: 1'b0, expResp: 8'h3C};
        vecs[2] = '{wr: 1'b1, addr: 4'd0,  data: 8'h5A, holdValid: 1'b1, expResp: 8'h3C};
        vecs[3] = '{wr: 1'b0, addr: 4'd0,  data: 8'hFF, holdValid: 1'b0, expResp: 8'h5A};
        vecs[4] = '{wr: 1'b1, addr: 4'd15, data: 8'hC3, holdValid: 1'b1, expResp: 8'h5A};
        vecs[5] = '{wr: 1'b0, addr: 4'd15, data: 8'h00, holdValid: 1'b1, expResp: 8'hC3};
        vecs[6] = '{wr: 1'b0, addr: 4'd3,  data: 8'h00, holdValid: 1'b0, expResp: 8'hA5};
        vecs[7] = '{wr: 1'b1, addr: 4'd7,  data: 8'h00, holdValid: 1'b0, expResp: 8'hA5};
        vecs[8] = '{wr: 1'b0, addr: 4'd7,  data: 8'h11, holdValid: 1'b0, expResp: 8'h00};

        // Reset state.
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int u = 0; u < int'(NDUT); u++) begin
            idleCheck(u, $sformatf("reset%0d", u));
            check($sformatf("reset%0d respData", u), 32'(respData[u]), 32'd0);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        invariantsOn = 1'b1;

        // Quiet bus: no edge activity for 10 cycles.
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            for (int u = 0; u < int'(NDUT); u++) idleCheck(u, $sformatf("quiet%0d", u));
        end

        for (int i = 0; i < 9; i++) begin
            v = vecs[i];
            runTxn(0, v.wr, v.addr, v.data, v.holdValid, v.expResp, $sformatf("vec%0d", i));
        end
        @(negedge clk);
        idleCheck(0, "after table");

        // Reset during the second STROBE cycle of a write.
        @(posedge clk);
        #1;
        reqValid[0] = 1'b1;
        reqWrite[0] = 1'b1;
        reqAddr[0]  = 4'd6;
        reqData[0]  = 8'h77;
        @(posedge clk);
        #1;
        reqValid[0] = 1'b0;
        @(negedge clk);
        check("abort setup cIn", 32'(cIn[0]), 32'h77);
        @(negedge clk);
        check("abort strobe1 we", 32'(cWe[0]), 32'h0040);
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(negedge clk);
        check("abort strobe2 we", 32'(cWe[0]), 32'h0040);
        @(posedge clk);
        #1;
        rst = 1'b0;
        refMem[0][6] = 8'h77;
        lastResp[0]  = '0;
        lastResp[1]  = '0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            idleCheck(0, $sformatf("abort+%0d", i));
        end
        check("abort respData", 32'(respData[0]), 32'd0);

        // Slow-timing instance: busy period of 7, one-cycle strobe.
        runTxn(1, 1'b1, 4'd9, 8'h96, 1'b0, lastResp[1], "sweep wr");
        runTxn(1, 1'b0, 4'd9, 8'h00, 1'b1, 8'h96, "sweep rd");
        runTxn(1, 1'b0, 4'd4, 8'h00, 1'b0, refMem[1][4], "sweep rd4");

        // Random traffic on both instances against the reference memory.
        for (int u = 0; u < int'(NDUT); u++) begin
            for (int n = 0; n < 30; n++) begin
                bit            wr   = 1'($urandom_range(0, 1));
                logic [AW-1:0] a    = AW'($urandom_range(0, ROWS - 1));
                logic [DW-1:0] d    = DW'($urandom);
                bit            hold = (n != 29) && ($urandom_range(0, 3) == 0);
                int            gap  = hold ? 0 : int'($urandom_range(0, 2));
                runTxn(u, wr, a, d, hold, wr ? lastResp[u] : refMem[u][a],
                       $sformatf("rnd%0d.%0d", u, n));
                for (int g = 0; g < gap; g++) begin
                    @(negedge clk);
                    idleCheck(u, $sformatf("rnd%0d.%0d gap", u, n));
                end
            end
            @(negedge clk);
            idleCheck(u, $sformatf("rnd%0d end", u));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/zsram_access_sequencer.md
Name: zsram_access_sequencer

Overview:
Sequencer directly upstream of the Zero Second RAM cell array: it accepts word read/write requests over a valid/ready handshake and drives each row's inputData, WriteEdge and ReadEdge with fixed setup/strobe/hold timing. It captures the shared outputData bit-lines on reads and returns one response per request. The array sits below it; the bus or register-file controller sits above it.

Parameters:
ADDR_WIDTH, 4, row address width; array has 2**ADDR_WIDTH rows
DATA_WIDTH, 8, cells per row (word width)
SETUP_CYCLES, 1, cycles data/address are stable before the strobe (1..15)
STROBE_CYCLES, 2, cycles the row WriteEdge/ReadEdge is held high (1..15)
HOLD_CYCLES, 1, cycles data is held after the strobe drops (1..15)

Ports:
Clock  input  1  single clock, all state updates on rising edge
Reset  input  1  synchronous, active-high
requestValid  input  1  request present
requestReady  output  1  sequencer can accept a request
requestWrite  input  1  1 = write, 0 = read
requestAddress  input  ADDR_WIDTH  row select
requestData  input  DATA_WIDTH  write word
responseValid  output  1  one-cycle pulse: request complete
responseData  output  DATA_WIDTH  read word (valid while responseValid)
cellInputData  output  DATA_WIDTH  shared write bit-lines to every row's inputData
cellWriteEdge  output  2**ADDR_WIDTH  per-row WriteEdge, one-hot or zero
cellReadEdge  output  2**ADDR_WIDTH  per-row ReadEdge, one-hot or zero
cellOutputData  input  DATA_WIDTH  shared read bit-lines from every row's outputData

Behaviour:
- Reset (sampled at Clock edge): state IDLE, requestReady=1, responseValid=0, responseData=0, cellInputData=0, cellWriteEdge=0, cellReadEdge=0, counter=0. Reset mid-operation aborts it: strobes drop at that edge, no response issued.
- States: IDLE -> SETUP -> STROBE -> HOLD -> RESPOND -> IDLE. All outputs registered.
- IDLE: requestReady=1. Handshake when requestValid & requestReady at an edge: latch write flag, address, data; go SETUP. requestReady=0 in every other state; no request accepted or queued while busy.
- SETUP: for writes cellInputData = latched data (reads: 0); no edges high. Stay SETUP_CYCLES cycles.
- STROBE: cellWriteEdge (write) or cellReadEdge (read) bit [address] high, all other bits 0, for exactly STROBE_CYCLES cycles; cellInputData unchanged. Reads: cellOutputData is registered into responseData at the edge ending the last STROBE cycle.
- HOLD: all edges 0; cellInputData still driven for HOLD_CYCLES cycles.
- RESPOND: responseValid=1 for exactly one cycle; cellInputData=0. Write responses leave responseData unchanged from its previous value. Next edge -> IDLE.
- Busy period (requestReady low) = SETUP_CYCLES+STROBE_CYCLES+HOLD_CYCLES+1 cycles; defaults: 5. Back-to-back requests: next handshake earliest in the cycle after RESPOND.
- Invariants: cellWriteEdge and cellReadEdge never both nonzero; never more than one bit set; cellInputData never changes while any edge is high.
- Phase counter 4 bits, reloaded on each state entry; parameter value 0 is illegal (elaboration check).
- Address 0 and 2**ADDR_WIDTH-1 map to bit 0 and MSB of edge vectors; no out-of-range addresses exist.

Test Plan:
- Reset then idle: all outputs 0 except requestReady=1; holding requestValid=0 for 10 cycles -> no edge activity.
- Write addr 3 data 0xA5 (defaults): cellInputData=0xA5 from cycle 1 to 4, cellWriteEdge=0x0008 in cycles 2-3 only, responseValid pulse in cycle 5, requestReady back high in cycle 6.
- Read addr 15 with bench driving cellOutputData=0x3C during strobe: cellReadEdge=0x8000 two cycles, responseData=0x3C with responseValid; cellInputData stays 0.
- Back-to-back write addr 0 / read addr 0 with requestValid held high: second handshake exactly one cycle after first RESPOND; requestReady never high during busy.
- Reset asserted during second STROBE cycle of a write: edges 0 and requestReady=1 at next edge, no responseValid pulse.
- Parameter sweep SETUP=3, STROBE=1, HOLD=2: strobe width 1 cycle, busy period 7 cycles; invariants checked by assertions throughout.
